// File: rtl/mult_div_unit.sv
// Iterative mult/multu/div/divu unit with internal HI/LO registers and a start/busy/done handshake.
// Optional MULT_EARLY_TERM_EN: multiply stops once the remaining multiplier magnitude is zero.
module mult_div_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

   state_t             state, stateNext;
   logic [1:0]         opReg;
   logic               negA, negB, divZero;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;      // mult: product; div: {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] opA;      // mult: shifted multiplicand; div: divisor in low half
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   hiReg, loReg;

   logic               inSigned, inNegA, inNegB;
   logic [WIDTH-1:0]   absA, absB;
   logic               mulLast, divLast, flip;
   logic [WIDTH:0]     remShift, remDiff;
   logic               remFits;

   assign inSigned = ~op[0];
   assign inNegA   = inSigned & a[WIDTH-1];
   assign inNegB   = inSigned & b[WIDTH-1];
   assign absA     = inNegA ? -a : a;
   assign absB     = inNegB ? -b : b;

   assign divLast  = (cnt == CNT_W'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
   assign mulLast  = divLast || (mplier[WIDTH-1:1] == '0);
`else
   assign mulLast  = divLast;
`endif

   assign remShift = acc[2*WIDTH-1:WIDTH-1];
   assign remFits  = remShift >= {1'b0, opA[WIDTH-1:0]};
   assign remDiff  = remShift - {1'b0, opA[WIDTH-1:0]};
   assign flip     = ~opReg[0] & (negA ^ negB);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (start) begin
            if (!op[1])        stateNext = MULT;
            else if (b == '0)  stateNext = DONE;
            else               stateNext = DIV;
         end
         MULT:    if (mulLast) stateNext = FIX;
         DIV:     if (divLast) stateNext = FIX;
         FIX:     stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         opReg   <= '0;
         negA    <= 1'b0;
         negB    <= 1'b0;
         divZero <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         opA     <= '0;
         mplier  <= '0;
         hiReg   <= '0;
         loReg   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               opReg   <= op;
               negA    <= inNegA;
               negB    <= inNegB;
               divZero <= op[1] & (b == '0);
               cnt     <= '0;
               mplier  <= absB;
               if (op[1]) begin
                  acc <= {{WIDTH{1'b0}}, absA};
                  opA <= {{WIDTH{1'b0}}, absB};
               end else begin
                  acc <= '0;
                  opA <= {{WIDTH{1'b0}}, absA};
               end
            end
            MULT: begin
               if (mplier[0]) acc <= acc + opA;
               opA    <= opA << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
            end
            DIV: begin
               acc <= remFits ? {remDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                              : {acc[2*WIDTH-2:0], 1'b0};
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               // Remainder follows the dividend sign, quotient the xor of signs.
               if (!opReg[1]) begin
                  {hiReg, loReg} <= flip ? -acc : acc;
               end else begin
                  loReg <= flip ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                  hiReg <= (~opReg[0] & negA) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign div_zero = (state == DONE) & divZero;
   assign hi       = hiReg;
   assign lo       = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO/div_zero queued at start, checked at done.
module tb_mult_div_unit;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   logic        clock, reset, start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [31:0] lastHi = '0, lastLo = '0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Start one op at the current negedge; pulseAt/abortAt (0 = off) inject a
   // second start or a reset at that cycle number.
   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int pulseAt, input int abortAt);
      exp_t        e, got;
      logic [63:0] p, q, r, mb;
      int          expLat, cyc, k;
      logic        busyOk, seen, quiet;
      e.hi = lastHi; e.lo = lastLo; e.dz = 1'b0;
      expLat = 34;
      case (o)
         2'b00: begin p = longint'($signed(x)) * longint'($signed(y)); e.hi = p[63:32]; e.lo = p[31:0]; end
         2'b01: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
         2'b10: if (y == 0) begin e.dz = 1'b1; expLat = 1; end
                else begin
                   q = longint'($signed(x)) / longint'($signed(y));
                   r = longint'($signed(x)) % longint'($signed(y));
                   e.lo = q[31:0]; e.hi = r[31:0];
                end
         default: if (y == 0) begin e.dz = 1'b1; expLat = 1; end
                  else begin e.lo = x / y; e.hi = x % y; end
      endcase
`ifdef MULT_EARLY_TERM_EN
      if (!o[1]) begin
         mb = (o == 2'b00 && y[31]) ? {32'b0, -y} : {32'b0, y};
         k = 1;
         for (int i = 0; i < 32; i++) if (mb[i]) k = i + 1;
         expLat = k + 2;
      end
`endif
      sb.push_back(e);
      op = o; a = x; b = y; start = 1'b1;
      cyc = 0; busyOk = 1'b1; seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(negedge clock);
         cyc++;
         start = 1'b0;
         if (cyc == 1) check({tag, " hilo stable"}, {hi, lo}, {lastHi, lastLo});
         if (cyc == pulseAt) begin start = 1'b1; op = 2'b01; a = ~x; b = 32'h5; end
         if (cyc == abortAt) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0; start = 1'b0;
            check({tag, " abort busy/hi/lo"}, {31'b0, busy, hi}, 64'h0);
            check({tag, " abort lo"}, {32'b0, lo}, 64'h0);
            void'(sb.pop_front());
            lastHi = '0; lastLo = '0;
            quiet = 1'b1;
            for (int i = 0; i < 40; i++) begin
               @(negedge clock);
               if (done || busy) quiet = 1'b0;
            end
            check({tag, " no done after abort"}, {63'b0, quiet}, 64'h1);
            return;
         end
         if (!busy) busyOk = 1'b0;
         if (done) seen = 1'b1;
      end
      check({tag, " latency"}, 64'(cyc), 64'(expLat));
      check({tag, " busy held"}, {63'b0, busyOk}, 64'h1);
      got = sb.pop_front();
      check({tag, " hi"}, {32'b0, hi}, {32'b0, got.hi});
      check({tag, " lo"}, {32'b0, lo}, {32'b0, got.lo});
      check({tag, " div_zero"}, {63'b0, div_zero}, {63'b0, got.dz});
      lastHi = got.hi; lastLo = got.lo;
      @(negedge clock);
      check({tag, " idle after done"}, {61'b0, busy, done, div_zero}, 64'h0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (2) @(negedge clock);
      check("reset flags", {61'b0, busy, done, div_zero}, 64'h0);
      check("reset hilo", {hi, lo}, 64'h0);
      reset = 1'b0;

      runOp("multu 11*3", 2'b01, 32'd11, 32'd3, 0, 0);
      runOp("mult -7*6", 2'b00, 32'hFFFF_FFF9, 32'd6, 0, 0);
      runOp("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
      runOp("divu max/16", 2'b11, 32'hFFFF_FFFF, 32'd16, 0, 0);
      runOp("divu setup", 2'b11, 32'h5678_1234, 32'h0001_0000, 0, 0);
      check("setup hilo", {hi, lo}, 64'h0000_1234_0000_5678);
      runOp("divu by zero", 2'b11, 32'd5, 32'd0, 0, 0);
      runOp("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      runOp("div by zero signed", 2'b10, 32'h8000_0000, 32'd0, 0, 0);
      runOp("mult start ignored", 2'b00, 32'h0001_2345, 32'hFFFF_0003, 5, 0);
      runOp("multu max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      runOp("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
      runOp("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0);
      runOp("mult reset abort", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 10);
      for (int i = 0; i < 6; i++) begin
         runOp("random op", 2'($urandom_range(0, 3)), $urandom, $urandom | 32'h1, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
